nx_ser_gen: RTL

NX_SER_GEN -- requirements
Module: nx_ser_gen

---
 rtl/nx_ser_gen_pkg.sv | 18 +
 rtl/nx_ser_lane.sv | 71 +++++++
 rtl/nx_ser_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nx_ser_gen_pkg.sv
// Shared limits and helpers for the nx_ser_gen serial word generator.
// Parameter legality bounds live here so the top can reject bad configurations.
package nx_ser_gen_pkg;

  localparam int DATA_SIZE_MIN = 2;
  localparam int DATA_SIZE_MAX = 10;
  localparam int LANES_MIN     = 1;
  localparam int LANES_MAX     = 8;
  localparam int DELAY_MAX_MIN = 0;
  localparam int DELAY_MAX_MAX = 63;
  localparam int TAP_W         = 6;

  function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] val,
                                                 input logic [TAP_W-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/nx_ser_lane.sv
// One serial lane: word shift register, registered pre-delay bit, and a
// free-running delay line with a tap mux selecting the output.
module nx_ser_lane
  import nx_ser_gen_pkg::*;
#(
  parameter int                  DATA_SIZE = 5,
  parameter int                  DELAY_MAX = 7,
  parameter logic [DATA_SIZE-1:0] IDLE     = '0,
  parameter logic                MSB_FIRST = 1'b0
) (
  input  logic                 FCK,
  input  logic                 RN,
  input  logic                 i_load,
  input  logic [DATA_SIZE-1:0] i_word,
  input  logic [TAP_W-1:0]     i_tap,
  output logic                 o_bit
);

  localparam int DLY_W = (DELAY_MAX > 0) ? DELAY_MAX : 1;

  // Reorder so the shift logic is always LSB-out regardless of bit order.
  function automatic logic [DATA_SIZE-1:0] order(input logic [DATA_SIZE-1:0] w);
    logic [DATA_SIZE-1:0] r;
    for (int j = 0; j < DATA_SIZE; j++) begin
      r[j] = MSB_FIRST ? w[DATA_SIZE-1-j] : w[j];
    end
    return r;
  endfunction

  localparam logic [DATA_SIZE-1:0] IDLE_ORD = order(IDLE);

  logic [DATA_SIZE-1:0] w_ord;
  logic [DATA_SIZE-1:0] r_sh;
  logic                 r_bit;
  logic [DLY_W-1:0]     r_dly;

  assign w_ord = order(i_word);

  always_ff @(posedge FCK or negedge RN) begin
    if (!RN) begin
      r_sh  <= IDLE_ORD;
      r_bit <= 1'b0;
    end else if (i_load) begin
      r_bit <= w_ord[0];
      r_sh  <= w_ord >> 1;
    end else begin
      r_bit <= r_sh[0];
      r_sh  <= r_sh >> 1;
    end
  end

  // Shifted every cycle so a tap change only re-times already valid history.
  always_ff @(posedge FCK or negedge RN) begin
    if (!RN) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= r_bit;
      for (int j = 1; j < DLY_W; j++) begin
        r_dly[j] <= r_dly[j-1];
      end
    end
  end

  always_comb begin
    o_bit = r_bit;
    for (int j = 1; j <= DELAY_MAX; j++) begin
      if (i_tap == TAP_W'(j)) o_bit = r_dly[j-1];
    end
  end

endmodule

// File: rtl/nx_ser_gen.sv
// Multi-lane parallel-to-serial generator with frame counter, valid/ready
// intake and a per-lane output delay register file.
module nx_ser_gen
  import nx_ser_gen_pkg::*;
#(
  parameter int                   DATA_SIZE = 5,
  parameter int                   LANES     = 4,
  parameter int                   DELAY_MAX = 7,
  parameter logic [DATA_SIZE-1:0] IDLE      = '0,
  parameter logic                 MSB_FIRST = 1'b0
) (
  input  logic                       FCK,
  input  logic                       RN,
  input  logic [LANES*DATA_SIZE-1:0] I,
  input  logic                       VLD,
  output logic                       RDY,
  output logic [LANES-1:0]           IO,
  output logic                       LD,
  input  logic                       DRL,
  input  logic [2:0]                 DRA,
  input  logic [TAP_W-1:0]           DRI,
  output logic [TAP_W-1:0]           DRO
);

  if (DATA_SIZE < DATA_SIZE_MIN || DATA_SIZE > DATA_SIZE_MAX) begin : g_bad_data_size
    $error("nx_ser_gen: DATA_SIZE out of range");
  end
  if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
    $error("nx_ser_gen: LANES out of range");
  end
  if (DELAY_MAX < DELAY_MAX_MIN || DELAY_MAX > DELAY_MAX_MAX) begin : g_bad_delay_max
    $error("nx_ser_gen: DELAY_MAX out of range");
  end

  localparam int                 CNT_W    = $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [TAP_W-1:0]   TAP_LIM  = TAP_W'(DELAY_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ld;
  logic [TAP_W-1:0] r_dro;
  logic [TAP_W-1:0] r_pend [LANES];
  logic [TAP_W-1:0] r_tap  [LANES];

  logic             w_load;
  logic             w_xfer;
  logic             w_dra_ok;
  logic [TAP_W-1:0] w_wr_val;
  logic [TAP_W-1:0] w_dro_nxt;

  // Handshake: RDY is high only in the last frame cycle; a transfer is
  // VLD && RDY and loads I into every lane on that same edge.
  assign w_load   = (r_cnt == CNT_LAST);
  assign RDY      = w_load;
  assign w_xfer   = VLD && RDY;
  assign w_dra_ok = (32'(DRA) < LANES);
  assign w_wr_val = clamp_tap(DRI, TAP_LIM);
  assign LD       = r_ld;
  assign DRO      = r_dro;

  always_ff @(posedge FCK or negedge RN) begin
    if (!RN) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
    end else begin
      r_cnt <= w_load ? '0 : r_cnt + 1'b1;
      r_ld  <= w_load;
    end
  end

  // Pending taps move to active taps only on the load edge.
  always_ff @(posedge FCK or negedge RN) begin
    if (!RN) begin
      for (int k = 0; k < LANES; k++) begin
        r_pend[k] <= '0;
        r_tap[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (DRL && w_dra_ok && (DRA == 3'(k))) r_pend[k] <= w_wr_val;
        if (w_load) r_tap[k] <= r_pend[k];
      end
    end
  end

  // Readback forwards a same-cycle write so DRO shows the new pending tap.
  always_comb begin
    w_dro_nxt = '0;
    if (w_dra_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (DRA == 3'(k)) w_dro_nxt = r_pend[k];
      end
      if (DRL) w_dro_nxt = w_wr_val;
    end
  end

  always_ff @(posedge FCK or negedge RN) begin
    if (!RN) r_dro <= '0;
    else     r_dro <= w_dro_nxt;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_SIZE-1:0] w_word;
    assign w_word = w_xfer ? I[k*DATA_SIZE +: DATA_SIZE] : IDLE;

    nx_ser_lane #(
      .DATA_SIZE (DATA_SIZE),
      .DELAY_MAX (DELAY_MAX),
      .IDLE      (IDLE),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .FCK    (FCK),
      .RN     (RN),
      .i_load (w_load),
      .i_word (w_word),
      .i_tap  (r_tap[k]),
      .o_bit  (IO[k])
    );
  end

endmodule
